// File: rtl/alu_pkg.sv
// Shared ALU definitions: data width, operation codes and the registered output bundle.
package alu_pkg;

    localparam int unsigned ALU_W = 32;

    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_SUB  = 4'd3;
    localparam logic [3:0] ALU_OR   = 4'd4;
    localparam logic [3:0] ALU_NOR  = 4'd5;
    localparam logic [3:0] ALU_AND  = 4'd6;
    localparam logic [3:0] ALU_CBZ  = 4'd7;
    localparam logic [3:0] ALU_XOR  = 4'd9;
    localparam logic [3:0] ALU_NAND = 4'd12;
    localparam logic [3:0] ALU_MOV  = 4'd13;

    typedef struct packed {
        logic [ALU_W-1:0] result;
        logic             zero;
        logic             carry;
        logic             negative;
        logic             overflow;
    } alu_out_t;

    localparam alu_out_t ALU_RESET_OUT = '{result: '0, zero: 1'b1, carry: 1'b0,
                                           negative: 1'b0, overflow: 1'b0};

endpackage

// File: rtl/alu_if.sv
// Operand/result bundle between a register-file controller and the ALU.
interface alu_if;
    import alu_pkg::*;

    logic [ALU_W-1:0] read_data1;
    logic [ALU_W-1:0] read_data2;
    logic [3:0]       alu_control_code;
    logic [ALU_W-1:0] result;
    logic             zero_flag;
    logic             carry_bit;
    logic             negative_flag;
    logic             overflow_flag;

    modport master (
        output read_data1, read_data2, alu_control_code,
        input  result, zero_flag, carry_bit, negative_flag, overflow_flag
    );

    modport slave (
        input  read_data1, read_data2, alu_control_code,
        output result, zero_flag, carry_bit, negative_flag, overflow_flag
    );

endinterface

// File: rtl/alu_addsub.sv
// Combinational 33-bit adder/subtractor; subtraction is A + ~B + 1 so carry means no-borrow.
module alu_addsub
    import alu_pkg::*;
(
    input  logic [ALU_W-1:0] a,
    input  logic [ALU_W-1:0] b,
    input  logic             sub,
    output logic [ALU_W-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    logic [ALU_W-1:0] b_eff;
    logic [ALU_W:0]   sum_wide;

    always_comb begin
        b_eff    = sub ? ~b : b;
        sum_wide = {1'b0, a} + {1'b0, b_eff} + {{ALU_W{1'b0}}, sub};
        sum      = sum_wide[ALU_W-1:0];
        carry    = sum_wide[ALU_W];
        // Same-sign operands into the adder with a sign flip on the output.
        overflow = (a[ALU_W-1] == b_eff[ALU_W-1]) && (sum[ALU_W-1] != a[ALU_W-1]);
    end

endmodule

// File: rtl/alu_unit.sv
// Registered single-cycle ALU: operation decode, flag generation and output register.
module alu_unit
    import alu_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic [ALU_W-1:0] readData1,
    input  logic [ALU_W-1:0] readData2,
    input  logic [3:0]       aluControlCode,
    output logic [ALU_W-1:0] result,
    output logic             zeroFlag,
    output logic             carryBit,
    output logic             negativeFlag,
    output logic             overflowFlag
);

    logic [ALU_W-1:0] as_sum;
    logic             as_carry;
    logic             as_overflow;
    alu_out_t         out_d;
    alu_out_t         out_q;

    alu_addsub u_addsub (
        .a        (readData1),
        .b        (readData2),
        .sub      (aluControlCode == ALU_SUB),
        .sum      (as_sum),
        .carry    (as_carry),
        .overflow (as_overflow)
    );

    always_comb begin
        out_d = '0;
        unique case (aluControlCode)
            ALU_ADD, ALU_SUB: begin
                out_d.result   = as_sum;
                out_d.carry    = as_carry;
                out_d.overflow = as_overflow;
            end
            ALU_OR:   out_d.result = readData1 | readData2;
            ALU_NOR:  out_d.result = ~(readData1 | readData2);
            ALU_AND:  out_d.result = readData1 & readData2;
            ALU_XOR:  out_d.result = readData1 ^ readData2;
            ALU_NAND: out_d.result = ~(readData1 & readData2);
            ALU_CBZ, ALU_MOV: out_d.result = readData2;
            default:  out_d.result = '0;
        endcase
        // Flags derive from the final result so undefined codes still report zero.
        out_d.zero     = (out_d.result == '0);
        out_d.negative = out_d.result[ALU_W-1];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            out_q <= ALU_RESET_OUT;
        end else begin
            out_q <= out_d;
        end
    end

    assign result       = out_q.result;
    assign zeroFlag     = out_q.zero;
    assign carryBit     = out_q.carry;
    assign negativeFlag = out_q.negative;
    assign overflowFlag = out_q.overflow;

endmodule

// File: tb/tb_alu_unit.sv
// Scoreboard bench for alu_unit: driver pushes reference-model results, monitor pops and compares.
module tb_alu_unit;
    import alu_pkg::*;

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        c;
        logic        n;
        logic        v;
    } exp_t;

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    alu_if bus ();

    alu_unit dut (
        .clock          (clk),
        .reset          (rst),
        .readData1      (bus.read_data1),
        .readData2      (bus.read_data2),
        .aluControlCode (bus.alu_control_code),
        .result         (bus.result),
        .zeroFlag       (bus.zero_flag),
        .carryBit       (bus.carry_bit),
        .negativeFlag   (bus.negative_flag),
        .overflowFlag   (bus.overflow_flag)
    );

    function automatic exp_t model(input logic r, input logic [31:0] a, input logic [31:0] b,
                                   input logic [3:0] op);
        exp_t        e;
        longint      sa;
        longint      sb;
        longint      s;
        longint unsigned u;
        e.res = 32'd0;
        e.c   = 1'b0;
        e.v   = 1'b0;
        if (r) begin
            e.z = 1'b1;
            e.n = 1'b0;
            return e;
        end
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            4'd2: begin
                u     = {32'd0, a} + {32'd0, b};
                e.res = u[31:0];
                e.c   = (u >= 64'h1_0000_0000);
                s     = sa + sb;
                e.v   = (s > SMAX) || (s < SMIN);
            end
            4'd3: begin
                e.res = a - b;
                e.c   = (a >= b);
                s     = sa - sb;
                e.v   = (s > SMAX) || (s < SMIN);
            end
            4'd4:    e.res = a | b;
            4'd5:    e.res = ~(a | b);
            4'd6:    e.res = a & b;
            4'd7:    e.res = b;
            4'd9:    e.res = a ^ b;
            4'd12:   e.res = ~(a & b);
            4'd13:   e.res = b;
            default: e.res = 32'd0;
        endcase
        e.z = (e.res == 32'd0);
        e.n = e.res[31];
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic issue(input logic r, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op);
        @(negedge clk);
        rst                  = r;
        bus.read_data1       = a;
        bus.read_data2       = b;
        bus.alu_control_code = op;
        exp_q.push_back(model(r, a, b, op));
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // Monitor: one registered output per issued operation, checked after the edge
    // and again after the mid-cycle input change to confirm it holds.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("result",   bus.result,                 e.res);
                chk("zero",     {31'd0, bus.zero_flag},     {31'd0, e.z});
                chk("carry",    {31'd0, bus.carry_bit},     {31'd0, e.c});
                chk("negative", {31'd0, bus.negative_flag}, {31'd0, e.n});
                chk("overflow", {31'd0, bus.overflow_flag}, {31'd0, e.v});
                @(negedge clk);
                #1;
                chk("hold_result", bus.result,             e.res);
                chk("hold_zero",   {31'd0, bus.zero_flag}, {31'd0, e.z});
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin : driver
        logic [3:0] op;
        rst                  = 1'b1;
        bus.read_data1       = $urandom;
        bus.read_data2       = $urandom;
        bus.alu_control_code = 4'd2;

        issue(1'b1, 32'h1234_5678, 32'h9ABC_DEF0, 4'd2);
        issue(1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 4'd3);
        issue(1'b0, 32'd15, 32'd15, 4'd2);
        issue(1'b0, 32'd15, 32'd15, 4'd7);
        issue(1'b0, 32'd15, 32'd0,  4'd7);
        issue(1'b0, 32'd10, 32'd15, 4'd3);
        issue(1'b0, 32'd15, 32'd15, 4'd3);
        issue(1'b0, 32'd5,  32'd10, 4'd6);
        issue(1'b0, 32'd5,  32'd10, 4'd4);
        issue(1'b0, 32'd5,  32'd10, 4'd9);
        issue(1'b0, 32'd5,  32'd10, 4'd5);
        issue(1'b0, 32'd5,  32'd10, 4'd12);
        issue(1'b0, 32'd5,  32'd10, 4'd13);
        issue(1'b0, 32'hFFFF_FFFF, 32'd1, 4'd2);
        issue(1'b0, 32'h7FFF_FFFF, 32'd1, 4'd2);
        issue(1'b0, 32'h7FFF_FFFF, 32'd1, 4'd15);
        issue(1'b0, 32'h8000_0000, 32'd1, 4'd3);
        issue(1'b0, 32'h0000_0003, 32'd7, 4'd2);
        issue(1'b1, 32'h0000_0003, 32'd7, 4'd2);
        issue(1'b0, 32'h0000_0003, 32'd7, 4'd2);

        for (int i = 0; i < 400; i++) begin
            op = 4'($urandom_range(15));
            issue(($urandom_range(29) == 0), pick_operand(), pick_operand(), op);
        end

        for (int i = 0; i < 4 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        repeat (2) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
